// File: rtl/hififo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hififo_pkg
//  Description : Shared constants and helpers for the hififo tpc datapath.
//  Revision    : 1.0  initial release
// ============================================================================
package hififo_pkg;

    localparam int HIFIFO_WORD_W = 64;
    localparam int WORDS_CNT_W   = 32;
    localparam int PAD_CNT_W     = 16;

    // Number of IN_W-wide lanes that make up one FIFO word.
    function automatic int lanes(input int in_w);
        return HIFIFO_WORD_W / in_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hififo_tpc_packer.sv
`default_nettype none
// ============================================================================
//  Module      : hififo_tpc_packer
//  Description : Packs IN_W samples little-endian into 64-bit tpc FIFO words,
//                with ready backpressure and zero-padding flush.
//  Revision    : 1.0  initial release
// ============================================================================
module hififo_tpc_packer
    import hififo_pkg::*;
#(
    parameter int IN_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [IN_W-1:0]          in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_flush,
    output logic [HIFIFO_WORD_W-1:0] fifo_data,
    output logic                     fifo_write,
    input  logic                     fifo_ready,
    output logic [WORDS_CNT_W-1:0]   words_written,
    output logic [PAD_CNT_W-1:0]     pad_words,
    output logic                     busy
);

    localparam int                  c_N      = lanes(IN_W);
    localparam int                  c_LANE_W = $clog2(c_N);
    localparam logic [c_LANE_W-1:0] c_LAST   = c_LANE_W'(c_N - 1);

    logic [HIFIFO_WORD_W-1:0] r_acc;
    logic [c_LANE_W-1:0]      r_lane;
    logic [HIFIFO_WORD_W-1:0] r_out_word;
    logic                     r_out_valid;
    logic                     r_flush_pend;
    logic [WORDS_CNT_W-1:0]   r_words_written;
    logic [PAD_CNT_W-1:0]     r_pad_words;

    logic                     w_drain;
    logic                     w_out_free;
    logic                     w_accept;
    logic                     w_word_done;
    logic [HIFIFO_WORD_W-1:0] w_acc_ins;
    logic [HIFIFO_WORD_W-1:0] w_acc_eff;
    logic [c_LANE_W-1:0]      w_lane_eff;
    logic                     w_flush_act;
    logic                     w_pad_load;

    // Gated by reset so a held word cannot escape in the reset cycle.
    assign fifo_write    = r_out_valid & fifo_ready & ~reset;
    assign w_drain       = fifo_write;
    assign w_out_free    = ~r_out_valid | w_drain;
    assign in_ready      = ~r_flush_pend & ((r_lane != c_LAST) | w_out_free);
    assign w_accept      = in_valid & in_ready;
    assign w_word_done   = w_accept & (r_lane == c_LAST);

    assign fifo_data     = r_out_word;
    assign words_written = r_words_written;
    assign pad_words     = r_pad_words;
    assign busy          = (r_lane != '0) | r_out_valid | r_flush_pend;

    always_comb begin
        w_acc_ins = r_acc;
        w_acc_ins[r_lane*IN_W +: IN_W] = in_data;
        w_acc_eff  = w_accept ? w_acc_ins : r_acc;
        w_lane_eff = r_lane;
        if (w_word_done) begin
            w_lane_eff = '0;
        end else if (w_accept) begin
            w_lane_eff = r_lane + c_LANE_W'(1);
        end
        // Upper lanes of the accumulator are always zero, so a flush of the
        // partial word naturally zero-pads it.
        w_flush_act = (r_flush_pend | in_flush) & (w_lane_eff != '0);
        w_pad_load  = w_flush_act & w_out_free;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc           <= '0;
            r_lane          <= '0;
            r_out_word      <= '0;
            r_out_valid     <= 1'b0;
            r_flush_pend    <= 1'b0;
            r_words_written <= '0;
            r_pad_words     <= '0;
        end else begin
            if (w_word_done) begin
                r_out_word  <= w_acc_ins;
                r_out_valid <= 1'b1;
            end else if (w_pad_load) begin
                r_out_word  <= w_acc_eff;
                r_out_valid <= 1'b1;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end

            if (w_word_done | w_pad_load) begin
                r_acc  <= '0;
                r_lane <= '0;
            end else begin
                r_acc  <= w_acc_eff;
                r_lane <= w_lane_eff;
            end

            r_flush_pend <= w_flush_act & ~w_out_free;

            if (fifo_write) begin
                r_words_written <= r_words_written + WORDS_CNT_W'(1);
            end
            if (w_pad_load) begin
                r_pad_words <= r_pad_words + PAD_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hififo_tpc_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hififo_tpc_packer
//  Description : Directed self-checking bench for hififo_tpc_packer (IN_W=16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hififo_tpc_packer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_flush = 1'b0;
    logic [63:0] fifo_data;
    logic        fifo_write;
    logic        fifo_ready = 1'b1;
    logic [31:0] words_written;
    logic [15:0] pad_words;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] wq[$];

    hififo_tpc_packer #(.IN_W(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_flush      (in_flush),
        .fifo_data     (fifo_data),
        .fifo_write    (fifo_write),
        .fifo_ready    (fifo_ready),
        .words_written (words_written),
        .pad_words     (pad_words),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    // Log every word the FIFO port actually takes.
    always @(negedge clock) begin
        if (fifo_write) wq.push_back(fifo_data);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_flush = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        wq.delete();
    endtask

    task automatic push(input logic [15:0] d, input logic fl);
        in_data  = d;
        in_valid = 1'b1;
        in_flush = fl;
        tick();
        in_valid = 1'b0;
        in_flush = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state
        fifo_ready = 1'b1;
        do_reset();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_fifo_write", 64'(fifo_write), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_fifo_data", fifo_data, 64'h0);

        // Streaming: two words at one sample per cycle
        for (int i = 1; i <= 8; i++) begin
            in_data  = 16'(i);
            in_valid = 1'b1;
            #1;
            check("stream_in_ready", 64'(in_ready), 64'd1);
            tick();
            check("stream_write", 64'(fifo_write), (i == 4 || i == 8) ? 64'd1 : 64'd0);
            if (i == 4) check("stream_word0", fifo_data, 64'h0004_0003_0002_0001);
            if (i == 8) check("stream_word1", fifo_data, 64'h0008_0007_0006_0005);
        end
        in_valid = 1'b0;
        tick();
        check("stream_count", 64'(words_written), 64'd2);
        check("stream_q_size", 64'(wq.size()), 64'd2);

        // Backpressure: held word plus full accumulator stalls sample 8
        do_reset();
        fifo_ready = 1'b0;
        for (int i = 1; i <= 7; i++) push(16'(16'h10 + i), 1'b0);
        in_data  = 16'h18;
        in_valid = 1'b1;
        #1;
        check("bp_stall_ready", 64'(in_ready), 64'd0);
        tick();
        check("bp_held_nowrite", 64'(fifo_write), 64'd0);
        check("bp_busy", 64'(busy), 64'd1);
        fifo_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        check("bp_write0", 64'(fifo_write), 64'd1);
        check("bp_data0", fifo_data, 64'h0014_0013_0012_0011);
        tick();
        in_valid = 1'b0;
        #1;
        check("bp_write1", 64'(fifo_write), 64'd1);
        check("bp_data1", fifo_data, 64'h0018_0017_0016_0015);
        tick();
        check("bp_idle", 64'(fifo_write), 64'd0);
        check("bp_count", 64'(words_written), 64'd2);
        check("bp_q_size", 64'(wq.size()), 64'd2);

        // Flush of a two-lane partial word
        do_reset();
        push(16'h000A, 1'b0);
        push(16'h000B, 1'b0);
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        #1;
        check("fl_write", 64'(fifo_write), 64'd1);
        check("fl_data", fifo_data, 64'h0000_0000_000B_000A);
        check("fl_pad", 64'(pad_words), 64'd1);
        tick();
        check("fl_busy", 64'(busy), 64'd0);
        check("fl_nowrite", 64'(fifo_write), 64'd0);

        // Flush on empty is a no-op
        do_reset();
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        #1;
        check("fe_nowrite", 64'(fifo_write), 64'd0);
        check("fe_busy", 64'(busy), 64'd0);
        check("fe_pad", 64'(pad_words), 64'd0);

        // Flush with the completing 4th sample: full word, no pad
        push(16'h0001, 1'b0);
        push(16'h0002, 1'b0);
        push(16'h0003, 1'b0);
        push(16'h0004, 1'b1);
        check("f4_write", 64'(fifo_write), 64'd1);
        check("f4_data", fifo_data, 64'h0004_0003_0002_0001);
        check("f4_pad", 64'(pad_words), 64'd0);
        tick();
        check("f4_busy", 64'(busy), 64'd0);

        // Flush with the 3rd sample: lanes 0-2 filled, lane 3 zero
        push(16'h0021, 1'b0);
        push(16'h0022, 1'b0);
        push(16'h0023, 1'b1);
        check("f3_write", 64'(fifo_write), 64'd1);
        check("f3_data", fifo_data, 64'h0000_0023_0022_0021);
        check("f3_pad", 64'(pad_words), 64'd1);
        tick();

        // Flush pending behind a held word; second pulse absorbed
        do_reset();
        fifo_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(16'(16'h30 + i), 1'b0);
        in_flush = 1'b1;
        tick();
        tick();
        in_flush = 1'b0;
        #1;
        check("fp_in_ready", 64'(in_ready), 64'd0);
        check("fp_busy", 64'(busy), 64'd1);
        check("fp_pad_early", 64'(pad_words), 64'd0);
        fifo_ready = 1'b1;
        #1;
        check("fp_write0", 64'(fifo_write), 64'd1);
        check("fp_data0", fifo_data, 64'h0034_0033_0032_0031);
        tick();
        check("fp_write1", 64'(fifo_write), 64'd1);
        check("fp_data1", fifo_data, 64'h0000_0000_0036_0035);
        check("fp_pad", 64'(pad_words), 64'd1);
        check("fp_ready_back", 64'(in_ready), 64'd1);
        tick();
        check("fp_idle", 64'(fifo_write), 64'd0);
        check("fp_busy_end", 64'(busy), 64'd0);
        check("fp_q_size", 64'(wq.size()), 64'd2);

        // Reset with held word and 3 partial lanes discards everything
        do_reset();
        fifo_ready = 1'b0;
        for (int i = 1; i <= 7; i++) push(16'(16'h40 + i), 1'b0);
        check("rm_busy_pre", 64'(busy), 64'd1);
        reset      = 1'b1;
        fifo_ready = 1'b1;
        #1;
        check("rm_nowrite_rst", 64'(fifo_write), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        check("rm_nowrite_after", 64'(fifo_write), 64'd0);
        check("rm_busy", 64'(busy), 64'd0);
        check("rm_count", 64'(words_written), 64'd0);
        wq.delete();
        tick();
        check("rm_nowrite_later", 64'(fifo_write), 64'd0);
        push(16'h0051, 1'b1);
        check("rm_fresh_write", 64'(fifo_write), 64'd1);
        check("rm_fresh_data", fifo_data, 64'h0000_0000_0000_0051);
        tick();

        // words_written wraps from all-ones to zero
        force dut.r_words_written = 32'hFFFF_FFFF;
        tick();
        release dut.r_words_written;
        #1;
        check("wrap_pre", 64'(words_written), 64'hFFFF_FFFF);
        push(16'h0061, 1'b1);
        tick();
        check("wrap_zero", 64'(words_written), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
